four_req_rr_arbiter: RTL
========================

# four_req_rr_arbiter

Round-robin arbiter that shares one downstream resource among four requesters. It issues a one-hot grant and a 2-bit encoded grant index, using the same encoding as the 4-to-2 encoder: requester 0→00, 1→01, 2→10, 3→11. It sits between the four request sources and the shared datapath, and holds each grant until the owner releases it.

## Interface
Parameters:
- CNT_W, 4, width of the hold-time counter (used only with timeout compiled in).
- MAX_HOLD, 15, maximum consecutive cycles one grant may be held (timeout build only); legal range 1 to 2^CNT_W−1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] high = requester i wants the resource; must stay high while owned.
- grant  output  4  one-hot grant, registered; all-zero when no owner.
- grant_idx  output  2  encoded owner index, registered; 2'b00 when no owner.
- grant_valid  output  1  high while any grant is active (equals |grant).
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked (timeout build only, else constant 0).

## Operation
- FSM states: IDLE and OWN.
- Round-robin pointer `last` (2 bits) holds the index of the most recent owner.
- IDLE: if req != 0, select the first asserted req[i] scanning last+1, last+2, last+3, last (mod 4). Then load grant/grant_idx, set last to i, and go to OWN. If req == 0, stay in IDLE with outputs zero.
- OWN: while req[grant_idx] stays high, hold the grant unchanged. Other requests are ignored (no preemption).
- OWN, release: if req[grant_idx] is low, clear grant, grant_idx and grant_valid, and go to IDLE.
- Index arithmetic: wraps modulo 4 (3+1 → 0).
- Changes on req for non-owners while in OWN have no effect; they are sampled only in IDLE.
- Reset (asynchronous assertion at any time, including mid-grant):
  - state = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0.
  - last = 2'b11, so requester 0 has top priority after reset.
  - Release of reset is synchronous to clk. The first arbitration happens on the first rising edge with rst_n high.

## Timing
- Request to grant: 1 cycle. A req sampled high at edge N in IDLE gives grant visible after edge N.
- Release to regrant: 2 cycles. The owner drops req before edge N; grant is low after edge N (IDLE bubble); the next owner is granted after edge N+1.
- The mandatory one-cycle bubble guarantees grant never switches directly between two requesters.
- All outputs are registered; there are no combinational paths from req to outputs.
- Simultaneous requests: resolved strictly by the rotation order from last+1.
- Owner drops req and another raises req in the same cycle: drop takes effect, bubble cycle, then the new requester is arbitrated.

## Configuration
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to OWN and increments each cycle in OWN.
  - When the counter equals MAX_HOLD and the owner's req is still high: clear grant, go to IDLE, and pulse timeout high for exactly one cycle (coincident with grant falling).
  - last keeps the revoked owner, so other requesters take precedence next.
  - Normal release on the same edge as expiry takes priority: no timeout pulse.
- Undefined: no counter is present, timeout is tied to 0, and a grant is held indefinitely.

## Test plan
- Reset: assert rst_n=0 mid-grant with req=4'b0100 → grant=0, grant_idx=00, grant_valid=0 immediately, without waiting for a clock edge. After release with req=4'b1111 → grant=4'b0001, grant_idx=00.
- Rotation: hold req=4'b1111, each owner drops its req for one cycle after owning it → grant_idx sequence is 00, 01, 10, 11, 00, with one zero-grant cycle between each.
- Sparse wrap: last=3, req=4'b1010 → grant_idx=01. Then, after release, req=4'b1000 → grant_idx=11. Then, after release, req=4'b1001 → grant_idx=00.
- No preemption: requester 2 owns the resource, req rises to 4'b0111 → grant stays 4'b0100 until req[2] falls, then one bubble cycle, then grant=4'b1000? No: only requesters 0 and 1 are asserted, so after the bubble grant=4'b0001 (scan 3, 0).
- Single requester re-request: req=4'b0010 toggles low for 1 cycle then high → grant 0010, then 0000 for 1 cycle, then 0010 again after 2 cycles.
- Timeout (ARB_HOLD_TIMEOUT_EN, MAX_HOLD=3): req=4'b0011 held → requester 0 granted for 4 cycles. Then timeout=1 for one cycle with grant=0, and on the next cycle grant=4'b0010.

Source files
------------

// File: rtl/four_req_rr_arbiter.sv
// Four-requester round-robin arbiter with one-hot and encoded grant, held until release.
// Optional hold-time limit compiled in with ARB_HOLD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among req from last+1 on the next edge
// OWN   | grant held for grant_idx until its req drops (or hold limit expires)
module four_req_rr_arbiter #(
   parameter int CNT_W    = 4,
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state_q, state_d;
   logic [1:0] last_q, last_d;
   logic [3:0] grant_d;
   logic [1:0] idx_d;
   logic       found;
   logic [1:0] pick;
   logic [1:0] cand;
   logic       hold_expired;
   logic       timeout_d;

   // Walk from the farthest candidate back so the nearest to last+1 wins.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      cand  = last_q;
      for (int k = 4; k >= 1; k--) begin
         cand = last_q + 2'(k);
         if (req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= (state_d == OWN && state_q == OWN) ? cnt_q + 1'b1 : '0;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      idx_d     = grant_idx;
      last_d    = last_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OWN;
               grant_d = 4'b0001 << pick;
               idx_d   = pick;
               last_d  = pick;
            end
         end
         OWN: begin
            if (!req[grant_idx]) begin
               state_d = IDLE;
               grant_d = 4'b0000;
               idx_d   = 2'b00;
            end else if (hold_expired) begin
               // Revoked owner stays in last so the others go first next time.
               state_d   = IDLE;
               grant_d   = 4'b0000;
               idx_d     = 2'b00;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            idx_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant     <= 4'b0000;
         grant_idx <= 2'b00;
         last_q    <= 2'b11;
      end else begin
         state_q   <= state_d;
         grant     <= grant_d;
         grant_idx <= idx_d;
         last_q    <= last_d;
      end
   end

   assign grant_valid = |grant;

endmodule
